// File: rtl/cmp_sequencer.sv
// Multi-cycle sequencer: fetches 16-bit instructions, issues compare-class ops to an external compare unit, writes results back.
// Define CMP_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they execute as NOPs.
module cmp_sequencer #(
    parameter int         PC_WIDTH  = 8,
    parameter logic [4:0] HALT_OP   = 5'b11111,
    parameter logic [1:0] CMP_CLASS = 2'b10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic [15:0]         instr_data,
    output logic [4:0]          cmp_opcode,
    output logic [2:0]          cmp_r1,
    output logic [2:0]          cmp_r2,
    input  logic [2:0]          cmp_rd,
    output logic                rf_we,
    output logic [2:0]          rf_waddr,
    output logic [2:0]          rf_wdata,
    output logic                busy,
    output logic                done,
    output logic                trap
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB
`ifdef CMP_ILLEGAL_TRAP_EN
        ,
        TRAP
`endif
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pc;
    logic [13:0]         ir;
    logic [2:0]          result;
    logic [4:0]          hold_op;
    logic [2:0]          hold_r1;
    logic [2:0]          hold_r2;

    logic [4:0] dec_op;
    logic       dec_halt;
    logic       dec_cmp;
    logic       unused_low_bits;

    assign dec_op          = instr_data[15:11];
    assign dec_halt        = (dec_op == HALT_OP);
    assign dec_cmp         = (dec_op[4:3] == CMP_CLASS);
    assign unused_low_bits = ^instr_data[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   next_state = DECODE;
            DECODE: begin
                if (dec_halt) begin
                    next_state = IDLE;
                end else if (dec_cmp) begin
                    next_state = EXEC;
                end else begin
`ifdef CMP_ILLEGAL_TRAP_EN
                    next_state = TRAP;
`else
                    next_state = FETCH;
`endif
                end
            end
            EXEC:    next_state = WB;
            WB:      next_state = FETCH;
            default: next_state = state;
        endcase
    end

    // Datapath registers; an illegal NOP advances the PC straight out of DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            ir      <= '0;
            result  <= '0;
            hold_op <= '0;
            hold_r1 <= '0;
            hold_r2 <= '0;
        end else begin
            if (state == IDLE && start) begin
                pc <= '0;
            end else if (state == WB) begin
                pc <= pc + 1'b1;
            end
`ifndef CMP_ILLEGAL_TRAP_EN
            else if (state == DECODE && !dec_halt && !dec_cmp) begin
                pc <= pc + 1'b1;
            end
`endif
            if (state == DECODE) begin
                ir <= instr_data[15:2];
            end
            if (state == EXEC) begin
                result  <= cmp_rd;
                hold_op <= ir[13:9];
                hold_r1 <= ir[5:3];
                hold_r2 <= ir[2:0];
            end
        end
    end

    // Compare-unit operands come live from the IR in EXEC and are held afterwards.
    always_comb begin
        instr_addr = pc;
        busy       = (state != IDLE);
        done       = (state == DECODE) && dec_halt;
        rf_we      = 1'b0;
        rf_waddr   = 3'b000;
        rf_wdata   = 3'b000;
        cmp_opcode = hold_op;
        cmp_r1     = hold_r1;
        cmp_r2     = hold_r2;
        trap       = 1'b0;
        if (state == EXEC) begin
            cmp_opcode = ir[13:9];
            cmp_r1     = ir[5:3];
            cmp_r2     = ir[2:0];
        end
        if (state == WB) begin
            rf_we    = 1'b1;
            rf_waddr = ir[8:6];
            rf_wdata = result;
        end
`ifdef CMP_ILLEGAL_TRAP_EN
        if (state == TRAP) begin
            trap = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_cmp_sequencer.sv
// Bench for cmp_sequencer: instruction table, hand-built corner sequences, and randomized programs
// checked against an instruction-level timing model. Honours CMP_ILLEGAL_TRAP_EN like the design.
module tb_cmp_sequencer;

    localparam logic [15:0] HALT_WORD = 16'hF800;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic [4:0]  cmp_opcode;
    logic [2:0]  cmp_r1;
    logic [2:0]  cmp_r2;
    logic [2:0]  cmp_rd;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [2:0]  rf_wdata;
    logic        busy;
    logic        done;
    logic        trap;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    logic       weLog   [0:1099];
    logic [2:0] waLog   [0:1099];
    logic [2:0] wdLog   [0:1099];
    logic       doneLog [0:1099];
    logic       busyLog [0:1099];
    logic       trapLog [0:1099];
    logic [7:0] addrLog [0:1099];

    typedef struct {
        logic [15:0] instr;
        bit          illegal;
        int          nWrites;
        logic [2:0]  wa;
        logic [2:0]  wd;
        int          doneCyc;
        int          busyCyc;
        logic [7:0]  addr3;
    } vecT;

    typedef struct {
        logic       busy;
        logic       done;
        logic       we;
        logic [7:0] addr;
        logic [4:0] op;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] wa;
        logic [2:0] wd;
    } expT;

    expT        trace[$];
    logic [4:0] lastOp;
    logic [2:0] lastR1;
    logic [2:0] lastR2;

    function automatic logic [2:0] cmpFn(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b);
        return a ^ b ^ op[2:0];
    endfunction

    cmp_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .cmp_opcode (cmp_opcode),
        .cmp_r1     (cmp_r1),
        .cmp_r2     (cmp_r2),
        .cmp_rd     (cmp_rd),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .done       (done),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    assign instr_data = mem[instr_addr];
    assign cmp_rd     = cmpFn(cmp_opcode, cmp_r1, cmp_r2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse start from IDLE, then log outputs for cycles 1..ncyc, optionally re-pulsing start mid-run.
    task automatic applyStimulus(input int ncyc, input int extraStart);
        start = 1'b1;
        tick();
        for (int c = 1; c <= ncyc; c++) begin
            weLog[c]   = rf_we;
            waLog[c]   = rf_waddr;
            wdLog[c]   = rf_wdata;
            doneLog[c] = done;
            busyLog[c] = busy;
            trapLog[c] = trap;
            addrLog[c] = instr_addr;
            start      = (c == extraStart);
            tick();
        end
        start = 1'b0;
    endtask

    // Expands the program in mem into per-cycle expectations by instruction cost.
    task automatic buildTrace();
        logic [7:0]  pc;
        logic [15:0] w;
        bit          fin;
        expT         e;
        trace.delete();
        pc  = 8'd0;
        fin = 1'b0;
        while (!fin) begin
            w      = mem[pc];
            e.busy = 1'b1;
            e.done = 1'b0;
            e.we   = 1'b0;
            e.addr = pc;
            e.op   = lastOp;
            e.r1   = lastR1;
            e.r2   = lastR2;
            e.wa   = 3'd0;
            e.wd   = 3'd0;
            if (w[15:11] == 5'b11111) begin
                trace.push_back(e);
                e.done = 1'b1;
                trace.push_back(e);
                e.busy = 1'b0;
                e.done = 1'b0;
                trace.push_back(e);
                fin = 1'b1;
            end else if (w[15:14] == 2'b10) begin
                trace.push_back(e);
                trace.push_back(e);
                lastOp = w[15:11];
                lastR1 = w[7:5];
                lastR2 = w[4:2];
                e.op   = lastOp;
                e.r1   = lastR1;
                e.r2   = lastR2;
                trace.push_back(e);
                e.we = 1'b1;
                e.wa = w[10:8];
                e.wd = cmpFn(w[15:11], w[7:5], w[4:2]);
                trace.push_back(e);
                pc = pc + 8'd1;
            end else begin
                trace.push_back(e);
                trace.push_back(e);
                pc = pc + 8'd1;
            end
        end
    endtask

    task automatic checkCycle(input int p, input int idx, input expT e);
        logic [31:0] act;
        logic [31:0] exp;
        act = {3'b0, busy, done, trap, rf_we, instr_addr, cmp_opcode, cmp_r1, cmp_r2,
               e.we ? rf_waddr : 3'b0, e.we ? rf_wdata : 3'b0};
        exp = {3'b0, e.busy, e.done, 1'b0, e.we, e.addr, e.op, e.r1, e.r2, e.wa, e.wd};
        checkOutput($sformatf("prog%0d cyc%0d", p, idx + 1), act, exp);
    endtask

    function automatic logic [15:0] randWord(input bit legalOnly);
        logic [15:0] w;
        logic [1:0]  cls;
        w = 16'($urandom);
        if (legalOnly || $urandom_range(0, 4) != 0) begin
            w[15:14] = 2'b10;
        end else begin
            cls = 2'($urandom_range(0, 2));
            if (cls == 2'b10) cls = 2'b11;
            w[15:14] = cls;
            if (cls == 2'b11) w[13:11] = 3'($urandom_range(0, 6));
        end
        return w;
    endfunction

    vecT vecs[7];

    initial begin
        int nw;
        int dc;
        int bc;
        int len;
        bit legalOnly;

        vecs[0] = '{16'h82A4, 1'b0, 1, 3'd2, 3'd4, 6, 6, 8'd0};
        vecs[1] = '{16'hBF78, 1'b0, 1, 3'd7, 3'd2, 6, 6, 8'd0};
        vecs[2] = '{16'h9003, 1'b0, 1, 3'd0, 3'd2, 6, 6, 8'd0};
        vecs[3] = '{16'hACFC, 1'b0, 1, 3'd4, 3'd5, 6, 6, 8'd0};
        vecs[4] = '{16'h194C, 1'b1, 0, 3'd0, 3'd0, 4, 4, 8'd1};
        vecs[5] = '{16'hC000, 1'b1, 0, 3'd0, 3'd0, 4, 4, 8'd1};
        vecs[6] = '{16'h7800, 1'b1, 0, 3'd0, 3'd0, 4, 4, 8'd1};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
`ifdef CMP_ILLEGAL_TRAP_EN
        legalOnly = 1'b1;
`else
        legalOnly = 1'b0;
`endif

        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset outputs",
                    32'({busy, done, trap, rf_we, instr_addr, cmp_opcode, cmp_r1, cmp_r2, rf_waddr, rf_wdata}), 32'd0);

        // Single-instruction programs followed by HALT.
        for (int i = 0; i < 7; i++) begin
            if (legalOnly && vecs[i].illegal) continue;
            mem[0] = vecs[i].instr;
            mem[1] = HALT_WORD;
            applyStimulus(8, -1);
            nw = 0;
            dc = -1;
            bc = 0;
            for (int c = 1; c <= 8; c++) begin
                if (weLog[c]) nw++;
                if (doneLog[c] && dc < 0) dc = c;
                if (busyLog[c]) bc++;
            end
            checkOutput($sformatf("vec%0d writes", i), 32'(nw), 32'(vecs[i].nWrites));
            if (vecs[i].nWrites > 0) begin
                checkOutput($sformatf("vec%0d we@4", i), 32'({weLog[4], waLog[4], wdLog[4]}),
                            32'({1'b1, vecs[i].wa, vecs[i].wd}));
            end
            checkOutput($sformatf("vec%0d done cycle", i), 32'(dc), 32'(vecs[i].doneCyc));
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(bc), 32'(vecs[i].busyCyc));
            checkOutput($sformatf("vec%0d addr@3", i), 32'(addrLog[3]), 32'(vecs[i].addr3));
        end

        // Two back-to-back compares then HALT.
        mem[0] = 16'h82A4;
        mem[1] = 16'hBF78;
        mem[2] = HALT_WORD;
        applyStimulus(12, -1);
        nw = 0;
        bc = 0;
        dc = 0;
        for (int c = 1; c <= 12; c++) begin
            if (weLog[c]) nw++;
            if (busyLog[c]) bc++;
            if (doneLog[c]) dc++;
        end
        checkOutput("b2b writes", 32'({weLog[4], waLog[4], wdLog[4], weLog[8], waLog[8], wdLog[8]}),
                    32'({1'b1, 3'd2, 3'd4, 1'b1, 3'd7, 3'd2}));
        checkOutput("b2b write count", 32'(nw), 32'd2);
        checkOutput("b2b pc sequence", 32'({addrLog[1], addrLog[5], addrLog[9]}), 32'({8'd0, 8'd1, 8'd2}));
        checkOutput("b2b done", 32'({doneLog[10], 8'(dc)}), 32'({1'b1, 8'd1}));
        checkOutput("b2b busy cycles", 32'(bc), 32'd10);

        // start re-pulsed during EXEC must not disturb the run.
        mem[1] = HALT_WORD;
        applyStimulus(8, 3);
        bc = 0;
        for (int c = 1; c <= 8; c++) if (busyLog[c]) bc++;
        checkOutput("start in exec", 32'({weLog[4], waLog[4], wdLog[4], doneLog[6], 8'(bc)}),
                    32'({1'b1, 3'd2, 3'd4, 1'b1, 8'd6}));

        // Reset during EXEC discards the pending write.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("reset in exec",
                    32'({busy, done, trap, rf_we, instr_addr, cmp_opcode, cmp_r1, cmp_r2, rf_waddr, rf_wdata}), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle after reset", 32'({busy, rf_we}), 32'd0);
        applyStimulus(8, -1);
        checkOutput("rerun after reset", 32'({addrLog[1], weLog[4], waLog[4], wdLog[4]}),
                    32'({8'd0, 1'b1, 3'd2, 3'd4}));

        // PC wrap from 255 to 0.
        for (int i = 0; i < 256; i++) mem[i] = 16'h82A4;
        mem[255] = 16'hBF78;
        applyStimulus(1026, -1);
        checkOutput("wrap fetch 255", 32'(addrLog[1021]), 32'd255);
        checkOutput("wrap write", 32'({weLog[1024], waLog[1024], wdLog[1024]}), 32'({1'b1, 3'd7, 3'd2}));
        checkOutput("wrap addr 0", 32'({busyLog[1025], addrLog[1025]}), 32'({1'b1, 8'd0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;

`ifdef CMP_ILLEGAL_TRAP_EN
        // Illegal opcode traps; start is ignored and only reset leaves.
        mem[0] = 16'h194C;
        mem[1] = HALT_WORD;
        applyStimulus(8, 5);
        checkOutput("trap before exit", 32'(trapLog[2]), 32'd0);
        nw = 0;
        for (int c = 3; c <= 8; c++) begin
            if (trapLog[c] && busyLog[c] && addrLog[c] == 8'd0 && !weLog[c] && !doneLog[c]) nw++;
        end
        checkOutput("trap held", 32'(nw), 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("trap cleared", 32'({trap, busy}), 32'd0);
`endif

        // Randomized programs against the instruction-level model.
        lastOp = 5'd0;
        lastR1 = 3'd0;
        lastR2 = 3'd0;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) mem[i] = randWord(legalOnly);
            mem[len] = {5'b11111, 11'($urandom)};
            buildTrace();
            start = 1'b1;
            tick();
            for (int i = 0; i < trace.size(); i++) begin
                checkCycle(p, i, trace[i]);
                start = trace[i].busy && ($urandom_range(0, 3) == 0);
                tick();
            end
            start = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_sequencer.md
CMP_SEQUENCER -- requirements
Module: cmp_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8: width of the instruction address / program counter.
REQ-002 Parameter HALT_OP, default 5'b11111: opcode that ends a program run.
REQ-003 Parameter CMP_CLASS, default 2'b10: opcode[4:3] value identifying compare-class instructions.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a run at PC=0; honoured only in IDLE.
REQ-007 instr_addr  output  PC_WIDTH  instruction memory address (current PC).
REQ-008 instr_data  input  16  instruction word: [15:11] opcode, [10:8] rd, [7:5] r1, [4:2] r2, [1:0] ignored; valid the cycle after instr_addr is presented.
REQ-009 cmp_opcode  output  5  opcode driven to the compare unit.
REQ-010 cmp_r1, cmp_r2  output  3 each  source register indices driven to the compare unit.
REQ-011 cmp_rd  input  3  combinational result from the compare unit.
REQ-012 rf_we  output  1  register-file write strobe, one cycle wide.
REQ-013 rf_waddr  output  3  register-file write index.
REQ-014 rf_wdata  output  3  register-file write data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when a run ends on HALT_OP.
REQ-017 trap  output  1  sticky illegal-opcode flag (see Configuration).

Function
REQ-018 States: IDLE, FETCH, DECODE, EXEC, WB (plus TRAP when CMP_ILLEGAL_TRAP_EN is defined).
REQ-019 IDLE -> FETCH on start; PC loaded with 0 on the same edge.
REQ-020 FETCH: instr_addr = PC; always -> DECODE next cycle.
REQ-021 DECODE: instr_data latched into the internal instruction register on the exiting edge.
REQ-022 DECODE exit, by latched opcode: == HALT_OP -> IDLE with done=1 for one cycle; opcode[4:3] == CMP_CLASS -> EXEC; otherwise illegal (REQ-031/032).
REQ-023 EXEC: cmp_opcode/cmp_r1/cmp_r2 driven from the instruction register; cmp_rd captured into a result register at end of cycle; -> WB.
REQ-024 WB: rf_we=1, rf_waddr=rd, rf_wdata=captured result; PC <= PC+1; -> FETCH.
REQ-025 Latency: exactly 4 cycles per compare instruction (FETCH, DECODE, EXEC, WB); HALT costs 2 cycles.
REQ-026 PC increments modulo 2^PC_WIDTH; 255 -> 0 at default width, with no flag.
REQ-027 cmp_* outputs hold their last values outside EXEC; rf_we is 0 outside WB.
REQ-028 start while busy is ignored and has no effect on PC or state.
REQ-029 Rst asserted in any state, including mid-instruction, wins over every other transition; a pending WB write is discarded.

Reset
REQ-030 On Rst: state=IDLE, PC=0, instruction and result registers=0, all outputs 0 (busy, done, trap, rf_we, instr_addr, cmp_*, rf_*).

Configuration
REQ-031 With CMP_ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE -> TRAP; trap=1, busy=1, PC frozen; TRAP exits only on Rst; start is ignored in TRAP.
REQ-032 With CMP_ILLEGAL_TRAP_EN undefined: an illegal opcode is a NOP; DECODE -> FETCH with PC+1, no rf_we pulse; trap tied 0; no TRAP state exists.

Verification
REQ-033 Program mem[0]=16'h8_2A4 form (op 5'b10000, rd=2, r1=5, r2=1), mem[1]=HALT; start -> rf_we exactly 4 cycles after start with rf_waddr=2 and rf_wdata=cmp_rd; done 2 cycles after WB; busy low thereafter.
REQ-034 Two back-to-back compare instructions followed by HALT -> writes 4 cycles apart, PC sequence 0,1,2, done pulse; total busy time 10 cycles.
REQ-035 Rst asserted during EXEC of mem[0] -> next cycle state IDLE, no rf_we pulse, all outputs 0; a later start reruns from PC=0.
REQ-036 Opcode 5'b00011 at mem[0]: with CMP_ILLEGAL_TRAP_EN -> trap=1 from the DECODE exit onward, instr_addr stays 0, start ignored; without it -> no write, PC advances to 1.
REQ-037 start pulsed during EXEC -> no change in sequence; PC=8'hFF compare instruction -> after WB instr_addr=0.
